// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: arbiter state encoding and index-width helper
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE} state_e;
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte bus plus uart transmit handshake and status
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*8-1:0] req_data;
  logic uart_transmit;
  logic uart_is_transmitting;
  logic [7:0] uart_tx_byte;
  logic [2:0] grant_id;
  logic busy;
  logic err_timeout;
  modport master (
    output req_valid, req_data, req_last, uart_is_transmitting,
    input req_ready, uart_transmit, uart_tx_byte, grant_id, busy, err_timeout
  );
  modport slave (
    input req_valid, req_data, req_last, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb.sv
// uart_tx_arbiter_rr_arb: first set mask bit at or after ptr, wrapping, as one-hot and index
module uart_tx_arbiter_rr_arb
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  // scanning farthest-first lets the nearest candidate overwrite the rest
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (mask_i[j]) idx_o = j;
    end
  end
  assign any_o = |mask_i;
  assign oh_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart transmitter among NREQ byte requesters
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int START_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = clog2(NREQ);
  localparam int TW = clog2(START_TIMEOUT);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, gid_q, gid_d, gid_nxt, win_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] data_q, data_d;
  logic lock_q, lock_d, last_q, last_d, any, accept, timeout;
  logic [NREQ-1:0] cand, win_oh;
  // a held packet lock narrows the field to the owner alone
  assign cand = lock_q ? bus.req_valid & (NREQ'(1) << owner_q) : bus.req_valid;
  uart_tx_arbiter_rr_arb #(.N(NREQ)) u_arb (
    .mask_i(cand),
    .ptr_i(ptr_q),
    .oh_o(win_oh),
    .idx_o(win_idx),
    .any_o(any)
  );
  assign accept = state_q == S_IDLE && any && !bus.uart_is_transmitting;
  assign gid_nxt = gid_q == IW'(NREQ - 1) ? '0 : gid_q + IW'(1);
  assign timeout = state_q == S_WAIT_START && !bus.uart_is_transmitting && timer_q == TW'(START_TIMEOUT - 1);
  assign bus.req_ready = accept ? win_oh : '0;
  assign bus.uart_transmit = state_q == S_ISSUE;
  assign bus.uart_tx_byte = data_q;
  assign bus.grant_id = 3'(gid_q);
  assign bus.busy = state_q != S_IDLE;
  assign bus.err_timeout = timeout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      lock_q <= 1'b0;
      gid_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      lock_q <= lock_d;
      gid_q <= gid_d;
      data_q <= data_d;
      last_q <= last_d;
      timer_q <= timer_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    lock_d = lock_q;
    gid_d = gid_q;
    data_d = data_q;
    last_d = last_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (accept) begin
        data_d = bus.req_data[8*win_idx +: 8];
        last_d = bus.req_last[win_idx];
        gid_d = win_idx;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: if (bus.uart_is_transmitting) begin
        state_d = S_WAIT_DONE;
      end else if (timeout) begin
        lock_d = 1'b0;
        ptr_d = gid_nxt;
        state_d = S_IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      S_WAIT_DONE: if (!bus.uart_is_transmitting) begin
        state_d = S_IDLE;
        lock_d = !last_q;
        owner_d = gid_q;
        ptr_d = last_q ? gid_nxt : ptr_q;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random requesters and uart timing against a cycle-budget scoreboard
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TO = 16;
  localparam int NCYC = 2500;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();
  uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int mptr, mowner, free_cyc, exp_tx, exp_err, ist_on, ist_off, cur_gid, win, h;
  bit mlock, did1, did2, hot, trig, ist, last;
  logic [7:0] cur_byte;
  logic [NREQ-1:0] v, exp_rdy;
  bit vb[NREQ];
  bit cnd[NREQ];
  int rem[NREQ];
  logic [7:0] val[NREQ];
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.uart_is_transmitting = 1'b0;
    mptr = 0;
    mowner = 0;
    mlock = 0;
    free_cyc = 0;
    exp_tx = -1;
    exp_err = -1;
    ist_on = 0;
    ist_off = 0;
    cur_byte = 8'h00;
    cur_gid = 0;
    did1 = 0;
    did2 = 0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      val[i] = 8'($urandom);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      hot = c >= 600 && c < 900;
      trig = c >= ist_on && c < ist_off && ((!did1 && c > 300) || (!did2 && c > 1500));
      rst = c < 2 || trig;
      ist = c < free_cyc ? (c >= ist_on && c < ist_off) : ($urandom_range(0, 5) == 0);
      v = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && (hot || $urandom_range(0, 3) == 0)) rem[i] = hot ? 1 : $urandom_range(1, 3);
        vb[i] = c >= 3 && rem[i] > 0 && (hot || $urandom_range(0, 7) != 0);
        v[i] = vb[i];
        bus.req_data[8*i +: 8] = val[i];
        bus.req_last[i] = rem[i] == 1;
      end
      bus.req_valid = v;
      bus.uart_is_transmitting = ist;
      #1;
      if (c < 2) continue;
      for (int i = 0; i < NREQ; i++) cnd[i] = vb[i] && (!mlock || i == mowner);
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && cnd[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
      end
      exp_rdy = (c >= free_cyc && !ist && win >= 0) ? NREQ'(1) << win : '0;
      chk("ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("transmit", 32'(bus.uart_transmit), 32'(c == exp_tx));
      chk("err_timeout", 32'(bus.err_timeout), 32'(c == exp_err));
      chk("busy", 32'(bus.busy), 32'(c < free_cyc));
      chk("tx_byte", 32'(bus.uart_tx_byte), 32'(cur_byte));
      chk("grant_id", 32'(bus.grant_id), cur_gid);
      if (trig) begin
        if (!did1) did1 = 1;
        else did2 = 1;
        mptr = 0;
        mlock = 0;
        free_cyc = c + 1;
        exp_tx = -1;
        exp_err = -1;
        ist_on = 0;
        ist_off = 0;
        cur_byte = 8'h00;
        cur_gid = 0;
      end else if (exp_rdy != '0) begin
        cur_byte = val[win];
        cur_gid = win;
        exp_tx = c + 1;
        last = rem[win] == 1;
        rem[win]--;
        val[win] = 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          exp_err = c + 1 + TO;
          free_cyc = exp_err + 1;
          ist_on = 0;
          ist_off = 0;
          mlock = 0;
          mptr = (win + 1) % NREQ;
        end else begin
          h = ($urandom_range(0, 19) == 0) ? 100 : $urandom_range(1, 6);
          ist_on = c + 2;
          ist_off = c + 2 + h;
          free_cyc = c + 3 + h;
          if (last) begin
            mlock = 0;
            mptr = (win + 1) % NREQ;
          end else begin
            mlock = 1;
            mowner = win;
          end
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
